// File: rtl/ncr5380_dma_master_if.sv
`default_nettype none
// ============================================================================
// Module   : ncr5380_dma_master_if
// Brief    : 5380 pseudo-DMA bus port (chip select, strobes, dack/dreq, data)
// Revision : 1.0
// ============================================================================
interface ncr5380_dma_master_if;
    logic       bus_cs;
    logic [2:0] bus_rs;
    logic       ior;
    logic       iow;
    logic       dack;
    logic       dreq;
    logic [7:0] wdata;
    logic [7:0] rdata;

    modport master (
        output bus_cs, bus_rs, ior, iow, dack, wdata,
        input  dreq, rdata
    );

    modport slave (
        input  bus_cs, bus_rs, ior, iow, dack, wdata,
        output dreq, rdata
    );
endinterface
`default_nettype wire

// File: rtl/ncr5380_dma_master.sv
`default_nettype none
// ============================================================================
// Module   : ncr5380_dma_master
// Brief    : Pseudo-DMA engine moving bytes between a buffer RAM and the 5380
// Revision : 1.0
// ============================================================================
module ncr5380_dma_master #(
    parameter int STROBE_CYC = 4,
    parameter int TIMEOUT    = 65535,
    parameter int AW         = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 dir,
    input  logic [15:0]          len,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [15:0]          remaining,
    ncr5380_dma_master_if.master bus,
    output logic [AW-1:0]        mem_addr,
    input  logic [7:0]           mem_rdata,
    output logic [7:0]           mem_wdata,
    output logic                 mem_we
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_REQ = 3'd1,
        S_FETCH    = 3'd2,
        S_STROBE   = 3'd3,
        S_RELEASE  = 3'd4,
        S_FINISH   = 3'd5
    } state_t;

    localparam logic [3:0]  c_strobe_last = 4'(STROBE_CYC - 1);
    localparam logic [15:0] c_timer_last  = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_dir;
    logic [3:0]  r_scnt;
    logic [15:0] r_timer;
    logic        r_adv;

    assign bus.bus_rs = 3'b000;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_dir       <= 1'b0;
            r_scnt      <= 4'd0;
            r_timer     <= 16'd0;
            r_adv       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            remaining   <= 16'd0;
            bus.bus_cs  <= 1'b0;
            bus.ior     <= 1'b0;
            bus.iow     <= 1'b0;
            bus.dack    <= 1'b0;
            bus.wdata   <= 8'h00;
            mem_addr    <= '0;
            mem_wdata   <= 8'h00;
            mem_we      <= 1'b0;
        end else begin
            done   <= 1'b0;
            mem_we <= 1'b0;
            r_adv  <= 1'b0;
            // Address advances one cycle after the strobe so a read-side
            // buffer write still lands on the byte's own address.
            if (r_adv) begin
                mem_addr <= mem_addr + AW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dir     <= dir;
                        remaining <= len;
                        mem_addr  <= '0;
                        timeout   <= 1'b0;
                        r_timer   <= 16'd0;
                        if (len == 16'd0) begin
                            done    <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            busy    <= 1'b1;
                            r_state <= S_WAIT_REQ;
                        end
                    end
                end

                S_WAIT_REQ: begin
                    if (abort) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_FINISH;
                    end else if (bus.dreq) begin
                        if (r_dir) begin
                            r_state <= S_FETCH;
                        end else begin
                            bus.bus_cs <= 1'b1;
                            bus.dack   <= 1'b1;
                            bus.ior    <= 1'b1;
                            r_scnt     <= 4'd0;
                            r_state    <= S_STROBE;
                        end
                    end else if (r_timer == c_timer_last) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_FINISH;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end

                S_FETCH: begin
                    // mem_addr has been stable since before WAIT_REQ, so the
                    // RAM output already reflects it.
                    bus.wdata  <= mem_rdata;
                    bus.bus_cs <= 1'b1;
                    bus.dack   <= 1'b1;
                    bus.iow    <= 1'b1;
                    r_scnt     <= 4'd0;
                    r_state    <= S_STROBE;
                end

                S_STROBE: begin
                    if (r_scnt == c_strobe_last) begin
                        bus.bus_cs <= 1'b0;
                        bus.dack   <= 1'b0;
                        bus.ior    <= 1'b0;
                        bus.iow    <= 1'b0;
                        remaining  <= remaining - 16'd1;
                        r_adv      <= 1'b1;
                        r_timer    <= 16'd0;
                        if (!r_dir) begin
                            mem_wdata <= bus.rdata;
                            mem_we    <= 1'b1;
                        end
                        r_state <= S_RELEASE;
                    end else begin
                        r_scnt <= r_scnt + 4'd1;
                    end
                end

                S_RELEASE: begin
                    if (abort) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_FINISH;
                    end else if (!bus.dreq) begin
                        if (remaining == 16'd0) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_FINISH;
                        end else begin
                            r_timer <= 16'd0;
                            r_state <= S_WAIT_REQ;
                        end
                    end else if (r_timer == c_timer_last) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_FINISH;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end

                S_FINISH: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
